// File: rtl/param_datapath_pkg.sv
// Shared types for the parametrised datapath: operation codes, control
// states and the encoded select values for AR/DR/AC.
package dp_pkg;

   typedef enum logic [3:0] {
      OP_PASS  = 4'd0,
      OP_ADD   = 4'd1,
      OP_SUB   = 4'd2,
      OP_INC   = 4'd3,
      OP_SHL   = 4'd4,
      OP_SHR   = 4'd5,
      OP_CLR   = 4'd6,
      OP_DIV   = 4'd7,
      OP_MEMRD = 4'd8,
      OP_MEMWR = 4'd9
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DIV,
      ST_MEM
   } state_e;

   // Special registers sit directly above the general registers.
   function automatic int sel_ar(input int nreg);
      return nreg;
   endfunction

   function automatic int sel_dr(input int nreg);
      return nreg + 1;
   endfunction

   function automatic int sel_ac(input int nreg);
      return nreg + 2;
   endfunction

endpackage

// File: rtl/param_datapath_if.sv
// Data-memory request/acknowledge port between the datapath (master) and
// the memory (slave).
interface param_datapath_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
);
   logic              mem_rd;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport master (
      output mem_rd, mem_wr, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_rd, mem_wr, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/param_datapath_seq_divider.sv
// Restoring shift-subtract unsigned divider, one quotient bit per clock.
// done_o/quotient_o are combinational so the owner can write back on the final iteration edge.
module seq_divider #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic [DATA_W-1:0] dividend_i,
   input  logic [DATA_W-1:0] divisor_i,
   output logic              done_o,
   output logic [DATA_W-1:0] quotient_o
);

   localparam int              CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

   logic              busy_q, busy_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] rem_q, rem_d;
   logic [DATA_W-1:0] quo_q, quo_d;
   logic [DATA_W-1:0] dvs_q, dvs_d;

   logic [DATA_W:0]   trial;
   logic              fits;
   logic [DATA_W-1:0] rem_step;
   logic [DATA_W-1:0] quo_step;

   // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      trial    = {rem_q, quo_q[DATA_W-1]};
      fits     = trial >= {1'b0, dvs_q};
      rem_step = fits ? (trial[DATA_W-1:0] - dvs_q) : trial[DATA_W-1:0];
      quo_step = {quo_q[DATA_W-2:0], fits};

      busy_d = busy_q;
      cnt_d  = cnt_q;
      rem_d  = rem_q;
      quo_d  = quo_q;
      dvs_d  = dvs_q;

      if (start_i) begin
         busy_d = 1'b1;
         cnt_d  = '0;
         rem_d  = '0;
         quo_d  = dividend_i;
         dvs_d  = divisor_i;
      end else if (busy_q) begin
         rem_d = rem_step;
         quo_d = quo_step;
         cnt_d = cnt_q + CNT_W'(1);
         if (cnt_q == LAST) busy_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         dvs_q  <= dvs_d;
      end
   end

   assign done_o     = busy_q && (cnt_q == LAST);
   assign quotient_o = quo_step;

endmodule

// File: rtl/param_datapath.sv
// Shared-bus datapath: AC, NREG general registers, AR and DR, a single-cycle
// ALU, a sequential divider and a handshaked data-memory port.
module param_datapath
   import dp_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int NREG   = 12,
   parameter int ADDR_W = 16,
   parameter int SEL_W  = $clog2(NREG + 3)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [3:0]                 op,
   input  logic [SEL_W-1:0]           b_sel,
   input  logic [SEL_W-1:0]           dst_sel,
   input  logic                       wr_en,
   input  logic [$clog2(DATA_W)-1:0]  shamt,
   output logic                       busy,
   output logic                       done,
   output logic                       z_flag,
   output logic [DATA_W-1:0]          c_bus,
   param_datapath_if.master           mem
);

   localparam logic [SEL_W-1:0] SEL_AR = SEL_W'(sel_ar(NREG));
   localparam logic [SEL_W-1:0] SEL_DR = SEL_W'(sel_dr(NREG));
   localparam logic [SEL_W-1:0] SEL_AC = SEL_W'(sel_ac(NREG));

   state_e            state_q, state_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              z_q, z_d;
   logic [DATA_W-1:0] c_bus_q, c_bus_d;
   logic              mem_rd_q, mem_rd_d;
   logic              mem_wr_q, mem_wr_d;
   logic [SEL_W-1:0]  dst_q, dst_d;
   logic              wr_q, wr_d;
   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];
   logic [DATA_W-1:0] ar_q, ar_d;
   logic [DATA_W-1:0] dr_q, dr_d;
   logic [DATA_W-1:0] ac_q, ac_d;

   logic [DATA_W-1:0] b_val;
   logic [DATA_W-1:0] alu_res;
   logic              div_start;
   logic              div_done;
   logic [DATA_W-1:0] div_quo;
   logic              wb_en;
   logic [SEL_W-1:0]  wb_sel;
   logic [DATA_W-1:0] wb_val;

   always_comb begin
      b_val = '0;
      for (int i = 0; i < NREG; i++) begin
         if (b_sel == SEL_W'(i)) b_val = regs_q[i];
      end
      if (b_sel == SEL_AR) b_val = ar_q;
      if (b_sel == SEL_DR) b_val = dr_q;
      if (b_sel == SEL_AC) b_val = ac_q;
   end

   always_comb begin
      alu_res = '0;
      case (op_e'(op))
         OP_PASS: alu_res = b_val;
         OP_ADD:  alu_res = ac_q + b_val;
         OP_SUB:  alu_res = ac_q - b_val;
         OP_INC:  alu_res = b_val + DATA_W'(1);
         OP_SHL:  alu_res = b_val << shamt;
         OP_SHR:  alu_res = b_val >> shamt;
         default: alu_res = '0;
      endcase
   end

   seq_divider #(.DATA_W(DATA_W)) u_div (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (div_start),
      .dividend_i (ac_q),
      .divisor_i  (b_val),
      .done_o     (div_done),
      .quotient_o (div_quo)
   );

   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      z_d       = z_q;
      c_bus_d   = c_bus_q;
      mem_rd_d  = mem_rd_q;
      mem_wr_d  = mem_wr_q;
      dst_d     = dst_q;
      wr_d      = wr_q;
      regs_d    = regs_q;
      ar_d      = ar_q;
      dr_d      = dr_q;
      ac_d      = ac_q;
      div_start = 1'b0;
      wb_en     = 1'b0;
      wb_sel    = dst_sel;
      wb_val    = alu_res;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               case (op_e'(op))
                  OP_DIV: begin
                     div_start = 1'b1;
                     state_d   = ST_DIV;
                     busy_d    = 1'b1;
                     dst_d     = dst_sel;
                     wr_d      = wr_en;
                  end
                  OP_MEMRD, OP_MEMWR: begin
                     state_d  = ST_MEM;
                     busy_d   = 1'b1;
                     mem_rd_d = (op_e'(op) == OP_MEMRD);
                     mem_wr_d = (op_e'(op) == OP_MEMWR);
                  end
                  default: begin
                     // Codes 10-15 only pulse done.
                     done_d = 1'b1;
                     if (op <= 4'd6) begin
                        c_bus_d = alu_res;
                        z_d     = (alu_res == '0);
                        wb_en   = wr_en;
                     end
                  end
               endcase
            end
         end
         ST_DIV: begin
            if (div_done) begin
               wb_en   = wr_q;
               wb_sel  = dst_q;
               wb_val  = div_quo;
               c_bus_d = div_quo;
               z_d     = (div_quo == '0);
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         ST_MEM: begin
            if (mem.mem_ack) begin
               if (mem_rd_q) dr_d = mem.mem_rdata;
               mem_rd_d = 1'b0;
               mem_wr_d = 1'b0;
               done_d   = 1'b1;
               busy_d   = 1'b0;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Selects above AC match nothing, so such writes are dropped.
      if (wb_en) begin
         for (int i = 0; i < NREG; i++) begin
            if (wb_sel == SEL_W'(i)) regs_d[i] = wb_val;
         end
         if (wb_sel == SEL_AR) ar_d = wb_val;
         if (wb_sel == SEL_DR) dr_d = wb_val;
         if (wb_sel == SEL_AC) ac_d = wb_val;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         z_q      <= 1'b0;
         c_bus_q  <= '0;
         mem_rd_q <= 1'b0;
         mem_wr_q <= 1'b0;
         dst_q    <= '0;
         wr_q     <= 1'b0;
         ar_q     <= '0;
         dr_q     <= '0;
         ac_q     <= '0;
         // NOTE: the register file is architecturally cleared by reset, so it is built from flops, not a RAM macro.
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         z_q      <= z_d;
         c_bus_q  <= c_bus_d;
         mem_rd_q <= mem_rd_d;
         mem_wr_q <= mem_wr_d;
         dst_q    <= dst_d;
         wr_q     <= wr_d;
         ar_q     <= ar_d;
         dr_q     <= dr_d;
         ac_q     <= ac_d;
         regs_q   <= regs_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign z_flag        = z_q;
   assign c_bus         = c_bus_q;
   assign mem.mem_rd    = mem_rd_q;
   assign mem.mem_wr    = mem_wr_q;
   assign mem.mem_addr  = ar_q[ADDR_W-1:0];
   assign mem.mem_wdata = dr_q;

endmodule
